// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store.
// Round-robin on ties, bounded wait with optional timeout.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_data_i,
  input  logic        bus_ack_i,
  output logic        stallreq_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t      state;
  logic        last_d;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        tmo;
  logic        pick_d;

  // Wait counter step and timeout detect; ack has priority over timeout
  assign cnt_nxt = cnt + 8'd1;
  assign tmo     = (TIMEOUT != 8'd0) && (cnt_nxt == TIMEOUT);

  // Data side wins unless fetch also asks and data went last
  assign pick_d  = mem_ce_i & (~if_ce_i | ~last_d);

  // Stall the pipeline while any request is still outstanding
  assign stallreq_o = (if_ce_i & ~if_ready_o)
                    | (mem_ce_i & ~mem_ready_o);

  // Arbitration FSM with registered bus and completion outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      cnt         <= 8'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_data_o  <= 32'h0;
      bus_sel_o   <= 4'h0;
      if_data_o   <= 32'h0;
      if_ready_o  <= 1'b0;
      mem_data_o  <= 32'h0;
      mem_ready_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      err_o       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_d) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= mem_we_i;
            bus_addr_o <= mem_addr_i;
            bus_sel_o  <= mem_sel_i;
            bus_data_o <= mem_data_i;
            cnt        <= 8'd0;
            last_d     <= 1'b1;
            state      <= GRANT_D;
          end else if (if_ce_i) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= if_addr_i;
            bus_sel_o  <= 4'hF;
            bus_data_o <= 32'h0;
            cnt        <= 8'd0;
            last_d     <= 1'b0;
            state      <= GRANT_I;
          end
        end
        GRANT_I: begin
          if (bus_ack_i) begin
            if_data_o  <= bus_data_i;
            if_ready_o <= 1'b1;
            bus_req_o  <= 1'b0;
            state      <= IDLE;
          end else if (tmo) begin
            if_data_o  <= 32'h0;
            if_ready_o <= 1'b1;
            err_o      <= 1'b1;
            bus_req_o  <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        GRANT_D: begin
          if (bus_ack_i) begin
            if (!bus_we_o) mem_data_o <= bus_data_i;
            mem_ready_o <= 1'b1;
            bus_req_o   <= 1'b0;
            state       <= IDLE;
          end else if (tmo) begin
            mem_data_o  <= 32'h0;
            mem_ready_o <= 1'b1;
            err_o       <= 1'b1;
            bus_req_o   <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter.
// Timeout instance uses TIMEOUT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_ready_o(if_ready_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_sel_o(bus_sel_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_ce_i = 0; if_addr_i = 0;
    mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0;
    mem_sel_i = 0; mem_data_i = 0;
    bus_data_i = 0; bus_ack_i = 0;
    tick(); tick();
    chk("rst_req", bus_req_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_ifrdy", if_ready_o, 0);
    chk("rst_memrdy", mem_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stallreq_o, 0);
    rst = 1'b1;

    // ack in idle ignored
    bus_ack_i = 1; bus_data_i = 32'hFFFF_FFFF;
    tick();
    chk("idle_ack_req", bus_req_o, 0);
    chk("idle_ack_ifrdy", if_ready_o, 0);
    chk("idle_ack_memrdy", mem_ready_o, 0);
    bus_ack_i = 0;

    // fetch only
    if_ce_i = 1; if_addr_i = 32'h100;
    tick();
    chk("f_req", bus_req_o, 1);
    chk("f_addr", bus_addr_o, 32'h100);
    chk("f_we", bus_we_o, 0);
    chk("f_sel", bus_sel_o, 4'hF);
    chk("f_bdata", bus_data_o, 0);
    chk("f_stall", stallreq_o, 1);
    chk("f_rdy0", if_ready_o, 0);
    bus_ack_i = 1; bus_data_i = 32'h0000_0013;
    tick();
    chk("f_rdy", if_ready_o, 1);
    chk("f_data", if_data_o, 32'h13);
    chk("f_stall_rdy", stallreq_o, 0);
    chk("f_req_drop", bus_req_o, 0);
    chk("f_err", err_o, 0);
    if_ce_i = 0; bus_ack_i = 0; bus_data_i = 0;
    tick();
    chk("f_rdy_pulse", if_ready_o, 0);
    chk("f_data_hold", if_data_o, 32'h13);
    chk("f_no_regrant", bus_req_o, 0);

    // tie from reset: D, I, D, I
    rst = 1'b0;
    #1;
    if_ce_i = 1; if_addr_i = 32'h200;
    mem_ce_i = 1; mem_we_i = 0;
    mem_addr_i = 32'h2000; mem_sel_i = 4'hF;
    tick();
    rst = 1'b1;
    tick();
    chk("t1_addr", bus_addr_o, 32'h2000);
    chk("t1_req", bus_req_o, 1);
    bus_ack_i = 1; bus_data_i = 32'hAAAA_0001;
    tick();
    chk("t1_memrdy", mem_ready_o, 1);
    chk("t1_memdata", mem_data_o, 32'hAAAA_0001);
    chk("t1_ifrdy", if_ready_o, 0);
    chk("t1_stall", stallreq_o, 1);
    bus_ack_i = 0;
    tick();
    chk("t2_addr", bus_addr_o, 32'h200);
    chk("t2_req", bus_req_o, 1);
    bus_ack_i = 1; bus_data_i = 32'h1111_0002;
    tick();
    chk("t2_ifrdy", if_ready_o, 1);
    chk("t2_ifdata", if_data_o, 32'h1111_0002);
    chk("t2_memdata_hold", mem_data_o, 32'hAAAA_0001);
    bus_ack_i = 0;
    tick();
    chk("t3_addr", bus_addr_o, 32'h2000);
    bus_ack_i = 1; bus_data_i = 32'hAAAA_0003;
    tick();
    chk("t3_memrdy", mem_ready_o, 1);
    chk("t3_memdata", mem_data_o, 32'hAAAA_0003);
    bus_ack_i = 0;
    tick();
    chk("t4_addr", bus_addr_o, 32'h200);
    if_ce_i = 0; mem_ce_i = 0;
    bus_ack_i = 1; bus_data_i = 32'h1111_0004;
    tick();
    chk("t4_ifrdy", if_ready_o, 1);
    chk("t4_ifdata", if_data_o, 32'h1111_0004);
    bus_ack_i = 0;
    tick();

    // store, ack after 4 grant cycles, ce dropped mid-way
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h3000;
    mem_sel_i = 4'b0011; mem_data_i = 32'hDEAD_BEEF;
    tick();
    mem_ce_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk("s_req", bus_req_o, 1);
      chk("s_we", bus_we_o, 1);
      chk("s_addr", bus_addr_o, 32'h3000);
      chk("s_sel", bus_sel_o, 4'b0011);
      chk("s_data", bus_data_o, 32'hDEAD_BEEF);
      chk("s_rdy0", mem_ready_o, 0);
      if (i == 3) begin
        bus_ack_i = 1; bus_data_i = 32'h1234_5678;
      end
      tick();
    end
    chk("s_rdy", mem_ready_o, 1);
    chk("s_memdata_keep", mem_data_o, 32'hAAAA_0003);
    chk("s_err", err_o, 0);
    chk("s_req_drop", bus_req_o, 0);
    bus_ack_i = 0;
    tick();
    chk("s_rdy_pulse", mem_ready_o, 0);

    // fetch timeout, no ack
    if_ce_i = 1; if_addr_i = 32'h400;
    tick();
    if_ce_i = 0;
    for (int i = 0; i < 3; i++) begin
      chk("to_req", bus_req_o, 1);
      chk("to_err0", err_o, 0);
      tick();
    end
    chk("to_req_hold", bus_req_o, 1);
    tick();
    chk("to_req_drop", bus_req_o, 0);
    chk("to_err", err_o, 1);
    chk("to_ifrdy", if_ready_o, 1);
    chk("to_ifdata", if_data_o, 0);
    tick();
    chk("to_err_pulse", err_o, 0);
    chk("to_rdy_pulse", if_ready_o, 0);

    // ack on the timeout cycle wins
    if_ce_i = 1; if_addr_i = 32'h500;
    tick();
    if_ce_i = 0;
    tick(); tick(); tick();
    chk("ta_req", bus_req_o, 1);
    bus_ack_i = 1; bus_data_i = 32'h0000_0055;
    tick();
    chk("ta_err", err_o, 0);
    chk("ta_ifrdy", if_ready_o, 1);
    chk("ta_ifdata", if_data_o, 32'h55);
    bus_ack_i = 0;
    tick();

    // reset during a data grant
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h6000;
    mem_sel_i = 4'hF;
    tick();
    chk("r_req", bus_req_o, 1);
    mem_ce_i = 0; if_ce_i = 1; if_addr_i = 32'h700;
    #2;
    rst = 1'b0;
    #1;
    chk("r_req0", bus_req_o, 0);
    chk("r_ifdata0", if_data_o, 0);
    chk("r_memdata0", mem_data_o, 0);
    chk("r_memrdy0", mem_ready_o, 0);
    chk("r_ifrdy0", if_ready_o, 0);
    chk("r_addr0", bus_addr_o, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("r_grant_req", bus_req_o, 1);
    chk("r_grant_addr", bus_addr_o, 32'h700);
    chk("r_grant_we", bus_we_o, 0);
    bus_ack_i = 1; bus_data_i = 32'h0000_0077;
    tick();
    chk("r_ifrdy", if_ready_o, 1);
    chk("r_ifdata", if_data_o, 32'h77);
    if_ce_i = 0; bus_ack_i = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
